dcache_wr_buffer: RTL and testbench

//  Write buffer between the dcache write port and the AXI bridge dcache_wr_* port. Queues

---
 rtl/dcache_wr_buffer_pkg.sv | 15 +
 rtl/dcache_wr_buffer_wb_entry_array.sv | 99 +++++++++
 rtl/dcache_wr_buffer.sv | 149 ++++++++++++++
 tb/tb_dcache_wr_buffer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_wr_buffer_pkg.sv
// Shared types and widths for the dcache write buffer.
package dcache_wr_buffer_pkg;

   localparam int WB_TYPE_WID = 3;
   localparam int WB_DATA_WID = 32;
   localparam int WB_STRB_WID = WB_DATA_WID / 8;

   // One-hot drain states
   typedef enum logic [2:0] {
      D_IDLE  = 3'b001,
      D_ISSUE = 3'b010,
      D_WAIT  = 3'b100
   } drain_state_e;

endpackage

// File: rtl/dcache_wr_buffer_wb_entry_array.sv
// Entry storage for the dcache write buffer: valid bits, payload registers,
// one write port, a head read port and per-entry word-address compare.
// WB_MERGE_EN adds a tail merge port and tail address match.
module wb_entry_array
   import dcache_wr_buffer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
)
(
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic                       wr_en,
   input  logic [$clog2(DEPTH)-1:0]   wr_ptr,
   input  logic [WB_TYPE_WID-1:0]     wr_type,
   input  logic [AW-1:0]              wr_addr,
   input  logic [DW/8-1:0]            wr_strb,
   input  logic [DW-1:0]              wr_data,
`ifdef WB_MERGE_EN
   input  logic                       mrg_en,
   input  logic [$clog2(DEPTH)-1:0]   tail_ptr,
   output logic                       tail_hit,
`endif
   input  logic                       clr_en,
   input  logic [$clog2(DEPTH)-1:0]   clr_ptr,
   input  logic [$clog2(DEPTH)-1:0]   rd_ptr,
   output logic [WB_TYPE_WID-1:0]     rd_type,
   output logic [AW-1:0]              rd_addr,
   output logic [DW/8-1:0]            rd_strb,
   output logic [DW-1:0]              rd_data,
   input  logic [AW-1:0]              chk_addr,
   output logic                       chk_hit
);

   localparam int SW = DW / 8;

   logic [DEPTH-1:0]       vld_q;
   logic [WB_TYPE_WID-1:0] type_q [DEPTH];
   logic [AW-1:0]          addr_q [DEPTH];
   logic [SW-1:0]          strb_q [DEPTH];
   logic [DW-1:0]          data_q [DEPTH];
   logic [DEPTH-1:0]       chk_vec;
   logic                   unused_chk_lo;

   // Valid bits: set on allocate, cleared on pop, all dropped on reset
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         vld_q <= '0;
      end else begin
         if (clr_en) vld_q[clr_ptr] <= 1'b0;
         if (wr_en)  vld_q[wr_ptr]  <= 1'b1;
      end
   end

   // Payload: full write on allocate, byte-wise merge into the tail otherwise
   always_ff @(posedge aclk) begin
      if (wr_en) begin
         type_q[wr_ptr] <= wr_type;
         addr_q[wr_ptr] <= wr_addr;
         strb_q[wr_ptr] <= wr_strb;
         data_q[wr_ptr] <= wr_data;
      end
`ifdef WB_MERGE_EN
      else if (mrg_en) begin
         for (int b = 0; b < SW; b++) begin
            if (wr_strb[b]) begin
               data_q[tail_ptr][8*b +: 8] <= wr_data[8*b +: 8];
               strb_q[tail_ptr][b]        <= 1'b1;
            end
         end
      end
`endif
   end

   // Head read port
   always_comb begin
      rd_type = type_q[rd_ptr];
      rd_addr = addr_q[rd_ptr];
      rd_strb = strb_q[rd_ptr];
      rd_data = data_q[rd_ptr];
   end

   // Word-granular hazard compare over every valid entry, in-flight head included
   always_comb begin
      chk_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         chk_vec[i] = vld_q[i] && (addr_q[i][AW-1:2] == chk_addr[AW-1:2]);
      end
   end

   assign chk_hit       = |chk_vec;
   assign unused_chk_lo = ^chk_addr[1:0];

`ifdef WB_MERGE_EN
   assign tail_hit = vld_q[tail_ptr] && (addr_q[tail_ptr][AW-1:2] == wr_addr[AW-1:2]);
`endif

endmodule

// File: rtl/dcache_wr_buffer.sv
// In-order write buffer between the dcache write port and the AXI bridge.
// Each entry is held until its B response returns so chk_hit covers it.
// Optional feature macro: WB_MERGE_EN (merge same-word pushes into the tail).
//
//  state   | meaning
//  D_IDLE  | nothing in flight, waiting for a valid entry
//  D_ISSUE | presenting head entry on out_wr_*, waiting for out_wr_rdy
//  D_WAIT  | head accepted by bridge, waiting for out_wr_done to pop it
module dcache_wr_buffer
   import dcache_wr_buffer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
)
(
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic                       in_wr_req,
   input  logic [WB_TYPE_WID-1:0]     in_wr_type,
   input  logic [AW-1:0]              in_wr_addr,
   input  logic [DW/8-1:0]            in_wr_wstrb,
   input  logic [DW-1:0]              in_wr_data,
   output logic                       in_wr_rdy,
   output logic                       out_wr_req,
   output logic [WB_TYPE_WID-1:0]     out_wr_type,
   output logic [AW-1:0]              out_wr_addr,
   output logic [DW/8-1:0]            out_wr_wstrb,
   output logic [DW-1:0]              out_wr_data,
   input  logic                       out_wr_rdy,
   input  logic                       out_wr_done,
   input  logic [AW-1:0]              chk_addr,
   output logic                       chk_hit,
   output logic                       wb_empty,
   output logic [$clog2(DEPTH):0]     wb_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]       count_q;
   drain_state_e           state_q, state_nxt;
   logic                   full, empty, push, alloc, pop;
   logic [WB_TYPE_WID-1:0] head_type;
   logic [AW-1:0]          head_addr;
   logic [DW/8-1:0]        head_strb;
   logic [DW-1:0]          head_data;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign pop   = (state_q == D_WAIT) && out_wr_done;

`ifdef WB_MERGE_EN
   logic [PTR_W-1:0] tail_ptr;
   logic             tail_hit, head_locked, merge_ok;

   // The head may not be modified once the bridge may have sampled it
   assign tail_ptr    = wr_ptr_q - PTR_W'(1);
   assign head_locked = (tail_ptr == rd_ptr_q) && (state_q != D_IDLE);
   assign merge_ok    = !empty && tail_hit && !head_locked;
   assign in_wr_rdy   = !full || merge_ok;
   assign push        = in_wr_req && in_wr_rdy;
   assign alloc       = push && !merge_ok;
`else
   assign in_wr_rdy   = !full;
   assign push        = in_wr_req && in_wr_rdy;
   assign alloc       = push;
`endif

   wb_entry_array #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_entries (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .wr_en    (alloc),
      .wr_ptr   (wr_ptr_q),
      .wr_type  (in_wr_type),
      .wr_addr  (in_wr_addr),
      .wr_strb  (in_wr_wstrb),
      .wr_data  (in_wr_data),
`ifdef WB_MERGE_EN
      .mrg_en   (push && merge_ok),
      .tail_ptr (tail_ptr),
      .tail_hit (tail_hit),
`endif
      .clr_en   (pop),
      .clr_ptr  (rd_ptr_q),
      .rd_ptr   (rd_ptr_q),
      .rd_type  (head_type),
      .rd_addr  (head_addr),
      .rd_strb  (head_strb),
      .rd_data  (head_data),
      .chk_addr (chk_addr),
      .chk_hit  (chk_hit)
   );

   // Pointers and occupancy; a same-cycle allocate and pop leave the count alone
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (alloc) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({alloc, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Drain state register
   always_ff @(posedge aclk) begin
      if (!aresetn) state_q <= D_IDLE;
      else          state_q <= state_nxt;
   end

   // Drain next-state and bridge request; data fields read zero outside D_ISSUE
   always_comb begin
      state_nxt    = state_q;
      out_wr_req   = 1'b0;
      out_wr_type  = '0;
      out_wr_addr  = '0;
      out_wr_wstrb = '0;
      out_wr_data  = '0;
      case (state_q)
         D_IDLE: begin
            if (!empty) state_nxt = D_ISSUE;
         end
         D_ISSUE: begin
            out_wr_req   = 1'b1;
            out_wr_type  = head_type;
            out_wr_addr  = head_addr;
            out_wr_wstrb = head_strb;
            out_wr_data  = head_data;
            if (out_wr_rdy) state_nxt = D_WAIT;
         end
         D_WAIT: begin
            if (out_wr_done) state_nxt = (count_q > CNT_W'(1)) ? D_ISSUE : D_IDLE;
         end
         default: state_nxt = D_IDLE;
      endcase
   end

   assign wb_count = count_q;
   assign wb_empty = empty && (state_q == D_IDLE);

endmodule

// File: tb/tb_dcache_wr_buffer.sv
// Directed bench for dcache_wr_buffer with a FIFO scoreboard of expected entries.
`timescale 1ns/1ps
module tb_dcache_wr_buffer;

   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int SW    = DW / 8;
   localparam int CW    = $clog2(DEPTH) + 1;
`ifdef WB_MERGE_EN
   localparam bit MERGE = 1'b1;
`else
   localparam bit MERGE = 1'b0;
`endif

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic          in_wr_req = 1'b0;
   logic [2:0]    in_wr_type = '0;
   logic [AW-1:0] in_wr_addr = '0;
   logic [SW-1:0] in_wr_wstrb = '0;
   logic [DW-1:0] in_wr_data = '0;
   logic          in_wr_rdy;
   logic          out_wr_req;
   logic [2:0]    out_wr_type;
   logic [AW-1:0] out_wr_addr;
   logic [SW-1:0] out_wr_wstrb;
   logic [DW-1:0] out_wr_data;
   logic          out_wr_rdy = 1'b0;
   logic          out_wr_done = 1'b0;
   logic [AW-1:0] chk_addr = '0;
   logic          chk_hit;
   logic          wb_empty;
   logic [CW-1:0] wb_count;

   always #5 aclk = ~aclk;

   dcache_wr_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .in_wr_req    (in_wr_req),
      .in_wr_type   (in_wr_type),
      .in_wr_addr   (in_wr_addr),
      .in_wr_wstrb  (in_wr_wstrb),
      .in_wr_data   (in_wr_data),
      .in_wr_rdy    (in_wr_rdy),
      .out_wr_req   (out_wr_req),
      .out_wr_type  (out_wr_type),
      .out_wr_addr  (out_wr_addr),
      .out_wr_wstrb (out_wr_wstrb),
      .out_wr_data  (out_wr_data),
      .out_wr_rdy   (out_wr_rdy),
      .out_wr_done  (out_wr_done),
      .chk_addr     (chk_addr),
      .chk_hit      (chk_hit),
      .wb_empty     (wb_empty),
      .wb_count     (wb_count)
   );

   typedef struct {
      logic [2:0]    t;
      logic [AW-1:0] a;
      logic [SW-1:0] s;
      logic [DW-1:0] d;
   } ent_t;

   ent_t q[$];
   int   checks = 0;
   int   errors = 0;
   bit   inflight = 1'b0;
   bit   exp_merge = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: check against the scoreboard before the edge, update it after
   task automatic step();
      bit   do_push, do_issue, do_pop, exp_rdy;
      ent_t e, tl;
      do_push  = 1'b0;
      do_issue = 1'b0;
      do_pop   = 1'b0;
      #1;
      if (aresetn) begin
         check("wb_count", wb_count, q.size());
         exp_rdy = (q.size() < DEPTH) || exp_merge;
         if (in_wr_req) begin
            check("in_wr_rdy", in_wr_rdy, exp_rdy);
            do_push = exp_rdy;
         end
         do_issue = out_wr_req && out_wr_rdy;
         if (do_issue) begin
            check("issue_while_inflight", inflight, 1'b0);
            check("issue_nonempty", q.size() != 0, 1'b1);
            if (q.size() != 0) begin
               check("issue_type", out_wr_type, q[0].t);
               check("issue_addr", out_wr_addr, q[0].a);
               check("issue_strb", out_wr_wstrb, q[0].s);
               check("issue_data", out_wr_data, q[0].d);
            end
         end
         do_pop = out_wr_done && inflight;
      end
      e.t = in_wr_type;
      e.a = in_wr_addr;
      e.s = in_wr_wstrb;
      e.d = in_wr_data;
      @(posedge aclk);
      #1;
      if (!aresetn) begin
         q.delete();
         inflight = 1'b0;
      end else begin
         if (do_push) begin
            if (exp_merge && q.size() != 0) begin
               tl = q.pop_back();
               for (int b = 0; b < SW; b++) begin
                  if (e.s[b]) begin
                     tl.d[8*b +: 8] = e.d[8*b +: 8];
                     tl.s[b] = 1'b1;
                  end
               end
               q.push_back(tl);
            end else begin
               q.push_back(e);
            end
         end
         if (do_issue) inflight = 1'b1;
         if (do_pop) begin
            void'(q.pop_front());
            inflight = 1'b0;
         end
      end
   endtask

   task automatic push(input logic [2:0] t, input logic [AW-1:0] a,
                       input logic [SW-1:0] s, input logic [DW-1:0] d);
      in_wr_req   = 1'b1;
      in_wr_type  = t;
      in_wr_addr  = a;
      in_wr_wstrb = s;
      in_wr_data  = d;
      step();
      in_wr_req   = 1'b0;
   endtask

   task automatic wait_issue();
      out_wr_rdy = 1'b1;
      for (int i = 0; i < 12 && !inflight; i++) step();
      out_wr_rdy = 1'b0;
      check("issue_seen", inflight, 1'b1);
   endtask

   task automatic drain_one();
      wait_issue();
      step();
      out_wr_done = 1'b1;
      step();
      out_wr_done = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      step();
      step();
      check("rst_count", wb_count, 0);
      check("rst_empty", wb_empty, 1);
      check("rst_req", out_wr_req, 0);
      check("rst_addr", out_wr_addr, 0);
      check("rst_strb", out_wr_wstrb, 0);
      check("rst_data", out_wr_data, 0);
      check("rst_rdy", in_wr_rdy, 1);
      check("rst_chk_hit", chk_hit, 0);
      aresetn = 1'b1;
      step();

      // 1: single push, two-cycle latency, held until rdy, popped on done
      push(3'd1, 32'h1C00_0010, 4'hF, 32'hDEAD_BEEF);
      check("t1_req_t1", out_wr_req, 0);
      step();
      check("t1_req_t2", out_wr_req, 1);
      step();
      step();
      check("t1_req_held", out_wr_req, 1);
      check("t1_addr", out_wr_addr, 32'h1C00_0010);
      check("t1_data", out_wr_data, 32'hDEAD_BEEF);
      out_wr_rdy = 1'b1;
      step();
      out_wr_rdy = 1'b0;
      check("t1_req_wait", out_wr_req, 0);
      step();
      step();
      check("t1_count_wait", wb_count, 1);
      out_wr_done = 1'b1;
      step();
      out_wr_done = 1'b0;
      check("t1_count_done", wb_count, 0);
      check("t1_empty", wb_empty, 1);

      // 2: fill, reject fifth push, stray done ignored, FIFO drain
      for (int i = 0; i < DEPTH; i++)
         push(3'(i), 32'h0000_1000 + 32'(16 * i), 4'(i + 1), 32'hA000_0000 + 32'(i));
      check("t2_full_rdy", in_wr_rdy, 0);
      check("t2_full_count", wb_count, 4);
      push(3'd7, 32'h0000_2000, 4'hF, 32'h5555_5555);
      check("t2_count_after_reject", wb_count, 4);
      out_wr_done = 1'b1;
      step();
      out_wr_done = 1'b0;
      check("t2_stray_done", wb_count, 4);
      for (int i = 0; i < DEPTH; i++) drain_one();
      check("t2_drained_empty", wb_empty, 1);

      // 3: hazard check covers the in-flight entry until its B response
      push(3'd2, 32'h0000_0100, 4'hF, 32'h1111_0000);
      wait_issue();
      chk_addr = 32'h0000_0102;
      step();
      check("t3_hit_wait", chk_hit, 1);
      step();
      check("t3_hit_wait2", chk_hit, 1);
      chk_addr = 32'h0000_0104;
      step();
      check("t3_miss_next_word", chk_hit, 0);
      chk_addr = 32'h0000_0102;
      step();
      check("t3_hit_again", chk_hit, 1);
      out_wr_done = 1'b1;
      step();
      out_wr_done = 1'b0;
      check("t3_hit_after_done", chk_hit, 0);

      // 4: push and done together keep the count, pointers wrap
      push(3'd3, 32'h0000_3000, 4'h1, 32'hC000_0001);
      push(3'd4, 32'h0000_3004, 4'h2, 32'hC000_0002);
      wait_issue();
      step();
      in_wr_req   = 1'b1;
      in_wr_type  = 3'd5;
      in_wr_addr  = 32'h0000_3008;
      in_wr_wstrb = 4'h4;
      in_wr_data  = 32'hC000_0003;
      out_wr_done = 1'b1;
      step();
      in_wr_req   = 1'b0;
      out_wr_done = 1'b0;
      check("t4_count_same", wb_count, 2);
      push(3'd6, 32'h0000_300C, 4'h8, 32'hC000_0004);
      check("t4_count3", wb_count, 3);
      for (int i = 0; i < 6 && q.size() != 0; i++) drain_one();
      check("t4_empty", wb_empty, 1);

      // 5: same-word pushes back to back before issue
      push(3'd4, 32'h0000_0200, 4'h3, 32'h0000_1122);
      exp_merge = MERGE;
      push(3'd4, 32'h0000_0200, 4'hC, 32'h3344_0000);
      exp_merge = 1'b0;
      check("t5_count", wb_count, MERGE ? 1 : 2);
      check("t5_req", out_wr_req, 1);
      check("t5_strb", out_wr_wstrb, MERGE ? 4'hF : 4'h3);
      check("t5_data", out_wr_data, MERGE ? 32'h3344_1122 : 32'h0000_1122);
      for (int i = 0; i < 4 && q.size() != 0; i++) drain_one();
      check("t5_empty", wb_empty, 1);

      // 6: reset while waiting on B with three entries
      push(3'd1, 32'h0000_4000, 4'hF, 32'h0404_0000);
      push(3'd2, 32'h0000_4010, 4'hF, 32'h0404_0001);
      push(3'd3, 32'h0000_4020, 4'hF, 32'h0404_0002);
      wait_issue();
      step();
      chk_addr = 32'h0000_4000;
      aresetn  = 1'b0;
      step();
      check("t6_count", wb_count, 0);
      check("t6_req", out_wr_req, 0);
      check("t6_empty", wb_empty, 1);
      check("t6_chk_hit", chk_hit, 0);
      aresetn = 1'b1;
      step();
      push(3'd5, 32'h0000_5000, 4'hA, 32'h0B0B_0B0B);
      drain_one();
      check("t6_recover_empty", wb_empty, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
